decode_ctrl_pipe: RTL and testbench

//  Registered RV32IM decode/control stage with parametrised multi-cycle M-extension sequencing.

---
 rtl/decode_ctrl_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Registered RV32IM decode/control stage between ID and EX. Decodes id_instr into a 22-bit
//   control bundle, holds it in an ID/EX register with a valid/ready handshake, and keeps
//   M-extension ops in the stage for a configurable number of cycles.
//
// Ports
//   clk        in   core clock
//   rst_n      in   synchronous reset, active-low
//   id_valid   in   id_instr valid
//   id_instr   in   [31:0] instruction word
//   id_ready   out  stage can accept this cycle
//   flush      in   squash the held instruction (taken branch/jump from EX)
//   ex_ready   in   EX consumes the bundle
//   ex_valid   out  bundle valid for EX
//   ex_ctrl    out  [21:0] {div_sel,mul_sel,four_imm,pc_rd1,rd1,ui,memwrite,memctrl[2:0],
//                   destsrc,branch,jump,immsrc[2:0],alusrc,aluctrl[3:0],regwrite}
//   ex_illegal out  held instruction undecodable
//
// Configuration
//   RV32M_DIV_EN  when defined, DIV/DIVU/REM/REMU decode as M ops with DIV_CYCLES latency;
//                 otherwise funct7=0000001 with funct3[2]=1 is illegal and div_sel is tied 0.

module decode_ctrl_pipe #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [21:0] ex_ctrl,
  output logic        ex_illegal
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  // Countdown preload: the bundle becomes visible when the counter reaches zero.
  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = id_instr[6:0];
  assign f3     = id_instr[14:12];
  assign f7     = id_instr[31:25];

  // Register and immediate fields are resolved downstream, not here.
  logic unused_instr;
  assign unused_instr = ^{id_instr[24:15], id_instr[11:7]};

  // Decoded fields
  logic       div_sel, mul_sel, four_imm, pc_rd1, rd1, ui, memwrite;
  logic [2:0] memctrl;
  logic       destsrc, branch, jump;
  logic [2:0] immsrc;
  logic       alusrc;
  logic [3:0] aluctrl;
  logic       regwrite;
  logic       dec_illegal;

  logic [21:0]      dec_ctrl;
  logic [CNT_W-1:0] dec_cnt;

  always_comb begin
    div_sel     = 1'b0;
    mul_sel     = 1'b0;
    four_imm    = 1'b1;
    pc_rd1      = 1'b1;
    rd1         = 1'b1;
    ui          = 1'b1;
    memwrite    = 1'b0;
    memctrl     = f3;
    destsrc     = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    immsrc      = 3'd0;
    alusrc      = 1'b0;
    aluctrl     = 4'd0;
    regwrite    = 1'b1;
    dec_illegal = 1'b0;

    case (opcode)
      OpcOp: begin
        aluctrl = {id_instr[30], f3};
        if (f7 == F7MulDiv) begin
          mul_sel = 1'b1;
`ifdef RV32M_DIV_EN
          div_sel = f3[2];
`else
          // Divide/remainder encodings decode as illegal without RV32M_DIV_EN.
          if (f3[2]) dec_illegal = 1'b1;
`endif
        end else if (f7 != F7Base && f7 != F7Alt) begin
          dec_illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        // Only the shift-right encoding uses bit 30 to pick arithmetic vs logical.
        aluctrl = {(f3 == 3'b101) ? id_instr[30] : 1'b0, f3};
        alusrc  = 1'b1;
      end
      OpcLoad: begin
        destsrc = 1'b1;
      end
      OpcStore: begin
        immsrc   = 3'd2;
        memwrite = 1'b1;
        regwrite = 1'b0;
      end
      OpcBranch: begin
        immsrc   = 3'd1;
        branch   = 1'b1;
        aluctrl  = {1'b0, f3};
        regwrite = 1'b0;
      end
      OpcLui: begin
        immsrc = 3'd3;
        ui     = 1'b0;
        rd1    = 1'b0;
      end
      OpcAuipc: begin
        immsrc = 3'd3;
        rd1    = 1'b0;
      end
      OpcJal: begin
        immsrc   = 3'd4;
        jump     = 1'b1;
        rd1      = 1'b0;
        four_imm = 1'b0;
      end
      OpcJalr: begin
        jump     = 1'b1;
        rd1      = 1'b0;
        pc_rd1   = 1'b0;
        four_imm = 1'b0;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (dec_illegal) begin
      dec_ctrl = '0;
      dec_cnt  = '0;
    end else begin
      dec_ctrl = {div_sel, mul_sel, four_imm, pc_rd1, rd1, ui, memwrite, memctrl, destsrc,
                  branch, jump, immsrc, alusrc, aluctrl, regwrite};
      if (mul_sel) dec_cnt = div_sel ? DivLoad : MulLoad;
      else         dec_cnt = '0;
    end
  end

  // ID/EX holding register
  logic             full_q;
  logic [CNT_W-1:0] cnt_q;
  logic [21:0]      ctrl_q;
  logic             illegal_q;

  logic accept;
  logic consume;

  assign ex_valid   = full_q && (cnt_q == '0);
  assign consume    = ex_valid && ex_ready;
  assign id_ready   = !full_q || consume;
  assign accept     = id_valid && id_ready && !flush;
  assign ex_ctrl    = ctrl_q;
  assign ex_illegal = illegal_q;

  // Priority: reset, flush, accept, consume, countdown. While counting, ex_valid is low so
  // neither accept nor consume can fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q    <= 1'b0;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      full_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      full_q    <= 1'b1;
      cnt_q     <= dec_cnt;
      ctrl_q    <= dec_ctrl;
      illegal_q <= dec_illegal;
    end else if (consume) begin
      full_q <= 1'b0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomised scoreboard bench for decode_ctrl_pipe. The driver predicts id_ready and pushes
// expected bundles with the cycle they must become visible; the monitor pops on consume/flush.

module tb_decode_ctrl_pipe;

  localparam int unsigned MulCycles = 3;
  localparam int unsigned DivCycles = 33;

  localparam logic [31:0] InsAddi = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] InsSw   = 32'h0010_2023; // sw x1,0(x0)
  localparam logic [31:0] InsBeq  = 32'h0000_0063; // beq x0,x0,0
  localparam logic [31:0] InsMul  = 32'h0220_8033; // mul x0,x1,x2
  localparam logic [31:0] InsDiv  = 32'h0220_C033; // div x0,x1,x2
  localparam logic [31:0] InsLw   = 32'h0000_2083; // lw x1,0(x0)
  localparam logic [31:0] InsBad  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [21:0] ex_ctrl;
  logic        ex_illegal;

  decode_ctrl_pipe #(
    .MUL_CYCLES (MulCycles),
    .DIV_CYCLES (DivCycles),
    .CNT_W      (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_ready   (id_ready),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .ex_illegal (ex_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [21:0] ctrl;
    logic        ill;
    int          lat;
    int          vcyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic run    = 1'b0;

  // Behavioural decode: what the bundle must hold and how long the op occupies the stage.
  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t       e;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    logic       legal = 1'b1;
    logic       is_m = 1'b0, is_div = 1'b0;
    logic       fi = 1'b1, prd = 1'b1, r1 = 1'b1, u = 1'b1, mw = 1'b0, ds = 1'b0;
    logic       br = 1'b0, jp = 1'b0, as = 1'b0, rw = 1'b1;
    logic [2:0] imm = 3'd0;
    logic [3:0] alu = 4'd0;
    e.lat = 1;
    e.vcyc = 0;
    if (opc == 7'h33) begin
      is_m = (f7 == 7'h01);
      legal = (f7 == 7'h00) || (f7 == 7'h20) || is_m;
      alu = {ins[30], f3};
`ifdef RV32M_DIV_EN
      is_div = is_m && f3[2];
`else
      if (is_m && f3[2]) legal = 1'b0;
`endif
      if (is_m) e.lat = is_div ? DivCycles : MulCycles;
    end else if (opc == 7'h13) begin
      as = 1'b1;
      alu = {(f3 == 3'd5) && ins[30], f3};
    end else if (opc == 7'h03) begin
      ds = 1'b1;
    end else if (opc == 7'h23) begin
      imm = 3'd2; mw = 1'b1; rw = 1'b0;
    end else if (opc == 7'h63) begin
      imm = 3'd1; br = 1'b1; rw = 1'b0; alu = {1'b0, f3};
    end else if (opc == 7'h37) begin
      imm = 3'd3; u = 1'b0; r1 = 1'b0;
    end else if (opc == 7'h17) begin
      imm = 3'd3; r1 = 1'b0;
    end else if (opc == 7'h6F) begin
      imm = 3'd4; jp = 1'b1; r1 = 1'b0; fi = 1'b0;
    end else if (opc == 7'h67) begin
      jp = 1'b1; r1 = 1'b0; prd = 1'b0; fi = 1'b0;
    end else begin
      legal = 1'b0;
    end
    if (legal) begin
      e.ctrl = {is_div, is_m, fi, prd, r1, u, mw, f3, ds, br, jp, imm, as, alu, rw};
      e.ill  = 1'b0;
    end else begin
      e.ctrl = '0;
      e.ill  = 1'b1;
      e.lat  = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h03;
      3: opc = 7'h23;
      4: opc = 7'h63;
      5: opc = 7'h37;
      6: opc = 7'h17;
      7: opc = 7'h6F;
      8: opc = 7'h67;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  // One stimulus cycle: drive after the falling edge, predict id_ready, record any accept.
  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    exp_t e;
    logic pred_ready;
    @(negedge clk);
    id_valid = v;
    id_instr = ins;
    ex_ready = rdy;
    flush    = fl;
    #1;
    pred_ready = (sb.size() == 0) || ((cyc >= sb[0].vcyc) && rdy);
    checks++;
    if (id_ready !== pred_ready) begin
      errors++;
      $display("FAIL id_ready cyc=%0d got=%b exp=%b", cyc, id_ready, pred_ready);
    end
    if (v && pred_ready && !fl) begin
      e = ref_model(ins);
      e.vcyc = cyc + e.lat;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    run      = 1'b0;
    rst_n    = 1'b0;
    id_valid = 1'b1;
    id_instr = InsAddi;
    ex_ready = 1'b1;
    flush    = 1'b0;
    sb.delete();
    repeat (n) @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 22'd0 || ex_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got valid=%b ctrl=%h ill=%b exp 0/000000/0",
               ex_valid, ex_ctrl, ex_illegal);
    end
    rst_n    = 1'b1;
    id_valid = 1'b0;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_id_ready got=%b exp=1", id_ready);
    end
    run = 1'b1;
  endtask

  // Monitor: checks visibility timing and bundle contents, retires entries on consume/flush.
  always @(negedge clk) begin
    logic exp_v;
    #3;
    if (run) begin
      exp_v = (sb.size() > 0) && (cyc >= sb[0].vcyc);
      checks++;
      if (ex_valid !== exp_v) begin
        errors++;
        $display("FAIL ex_valid cyc=%0d got=%b exp=%b", cyc, ex_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (ex_ctrl !== sb[0].ctrl || ex_illegal !== sb[0].ill) begin
          errors++;
          $display("FAIL bundle cyc=%0d got ctrl=%h ill=%b exp ctrl=%h ill=%b",
                   cyc, ex_ctrl, ex_illegal, sb[0].ctrl, sb[0].ill);
        end
      end
      if (flush) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (exp_v && ex_ready) begin
        void'(sb.pop_front());
      end
    end
  end

`ifdef RV32M_DIV_EN
  localparam logic [31:0] InsLong = InsDiv;
  localparam int          LongLat = DivCycles;
`else
  localparam logic [31:0] InsLong = InsMul;
  localparam int          LongLat = MulCycles;
`endif

  initial begin
    rst_n    = 1'b0;
    id_valid = 1'b0;
    id_instr = '0;
    ex_ready = 1'b0;
    flush    = 1'b0;

    do_reset(2);

    // Back-to-back stream
    drive(1'b1, InsAddi, 1'b1, 1'b0);
    drive(1'b1, InsSw,   1'b1, 1'b0);
    drive(1'b1, InsBeq,  1'b1, 1'b0);

    // Multiply occupies the stage; the next op waits behind it
    drive(1'b1, InsMul, 1'b1, 1'b0);
    for (int i = 0; i < int'(MulCycles); i++) drive(1'b1, InsAddi, 1'b1, 1'b0);

    // Backpressure with a load held
    drive(1'b1, InsLw, 1'b1, 1'b0);
    repeat (4) drive(1'b1, InsAddi, 1'b0, 1'b0);
    drive(1'b1, InsAddi, 1'b1, 1'b0);
    drive(1'b0, InsAddi, 1'b1, 1'b0);

    // Flush at cnt==1 of a long op, accept in the flush cycle is dropped
    drive(1'b1, InsLong, 1'b1, 1'b0);
    for (int i = 0; i < LongLat - 2; i++) drive(1'b0, InsAddi, 1'b1, 1'b0);
    drive(1'b1, InsAddi, 1'b1, 1'b1);
    drive(1'b1, InsAddi, 1'b1, 1'b0);
    drive(1'b0, InsAddi, 1'b1, 1'b0);

    // Divide (illegal in the default build) and unknown opcode
    drive(1'b1, InsDiv, 1'b1, 1'b0);
    repeat (DivCycles) drive(1'b1, InsBad, 1'b1, 1'b0);
    drive(1'b0, InsBad, 1'b1, 1'b0);

    // Reset in the middle of a countdown
    drive(1'b1, InsMul, 1'b1, 1'b0);
    drive(1'b0, InsAddi, 1'b1, 1'b0);
    do_reset(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    end

    // Drain
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      drive(1'b0, 32'd0, 1'b1, 1'b0);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
